exp_operand_loader: RTL and testbench
=====================================

Name: exp_operand_loader

Overview:
Word-serial front end for the modular exponentiation core. It accepts 32-bit words over a valid/ready stream and assembles the five 512-bit operands: modulus, Rmodm, Rsquaredmodm, exponent and x. On command it pulses the core's start, waits for done, captures the 512-bit result and streams it back out as 32-bit words. It sits between the host bus/DMA shim and the exponentiation core, which it drives directly.

Parameters:
WORD_W, 32, stream word width in bits.
N_BITS, 512, operand/result width; must be a multiple of WORD_W.
WORDS, N_BITS/WORD_W (16), words per operand; derived, not overridden.

Ports:
clk  in  1  clock
resetn  in  1  reset
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid&in_ready
in_data  in  WORD_W  input word
in_sel  in  3  operand select: 0 modulus, 1 Rmodm, 2 Rsquaredmodm, 3 exponent, 4 x, 5-7 invalid
cmd_start  in  1  run request, single-cycle pulse
modulus, rmodm, rsquaredmodm, exponent, x  out  N_BITS each  operand registers, wired to the core
exp_start  out  1  core startExponentiation
exp_done  in  1  core done (one-cycle pulse)
exp_result  in  N_BITS  core A_result
out_valid  out  1  result word valid
out_ready  in  1  result word consumed
out_data  out  WORD_W  result word
out_last  out  1  high with the final (16th) result word
busy  out  1  state != IDLE
err  out  1  one-cycle pulse: cmd_start rejected

Behaviour:
- Reset: clk and resetn, synchronous, active-low. On reset: all operand registers, the result register, counters and loaded flags go to 0; state goes to IDLE. in_ready=1 (IDLE); exp_start, out_valid, out_last, busy and err are 0.
- FSM states: IDLE, START, WAIT, DRAIN.
- IDLE:
  - in_ready=1.
  - Each handshake shifts the selected register right by WORD_W, loading in_data at the MSB end. The first word is therefore the least-significant, and after 16 words word0 sits in [31:0].
  - A single 4-bit word counter plus a 3-bit current-sel register track progress. An accepted word whose in_sel differs from current-sel restarts the counter at 0 for that operand.
  - A word at counter 0 clears that operand's loaded flag. The word completing counter==15 sets the flag and resets the counter to 0.
  - A word with in_sel 5-7 is accepted and discarded with no state change.
- cmd_start in IDLE:
  - If all 5 loaded flags are set (registered values from before this cycle), go to START next cycle.
  - Otherwise pulse err for 1 cycle and stay in IDLE.
  - An input word accepted in the same cycle is still written, but does not count toward this start check.
- cmd_start outside IDLE is ignored, with no err.
- START: exp_start=1 for exactly one cycle, then WAIT. Latency is cmd_start at cycle T -> exp_start high at T+1.
- WAIT: hold all operand registers stable; in_ready=0. On exp_done, capture exp_result into the result shift register, reset the counter, and go to DRAIN on the next cycle. There is no timeout.
- DRAIN:
  - out_valid=1 and out_data=result[31:0].
  - On each out_valid&out_ready, shift the result right by WORD_W and increment the counter.
  - out_last=1 when counter==15. The handshake on the last word returns to IDLE.
  - out_data and out_valid stay stable while out_ready=0.
- exp_done outside WAIT is ignored.
- Loaded flags persist across runs; only reset clears them. A re-run after reloading only x (or only the exponent) is legal.
- resetn low in any state aborts immediately to the reset values. The core shares resetn.
- busy=1 in START, WAIT and DRAIN.

Test Plan:
- Load modulus=0xB (16 words, word0=0xB, rest 0), with Rmodm, Rsquaredmodm, exponent=3 and x=2 computed for N=512. Issue cmd_start, with the stub core returning exp_result=8 ten cycles after exp_start -> exp_start high exactly 1 cycle at T+1; out words 8,0,...,0 with out_last on the 16th; busy drops after the last handshake.
- cmd_start after loading only 4 operands -> err pulses 1 cycle, no exp_start, state stays IDLE.
- Load 7 words to sel 4, then switch to sel 3 and send 16 words -> exponent is correct, x's loaded flag is cleared, and cmd_start gives err.
- DRAIN with out_ready toggled 1,0,0,1 pattern -> out_data is held during stalls, exactly 16 handshakes occur, and the word order matches result LSW first.
- Assert in_valid during WAIT -> in_ready=0, no register change; cmd_start during WAIT -> ignored.
- Pull resetn low in WAIT and in mid-DRAIN -> next cycle all outputs are at reset values, the loaded flags are clear, and a later cmd_start without reload gives err.

Source files
------------

// File: rtl/exp_operand_loader_if.sv
// exp_operand_loader_if: input word stream and result word stream between host shim and loader
interface exp_operand_loader_if #(parameter int WORD_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic [2:0]        in_sel;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  modport master (output in_valid, in_data, in_sel, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave (input in_valid, in_data, in_sel, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/exp_operand_loader.sv
// exp_operand_loader: assembles modexp operands from a word stream, runs the core, streams the result back
module exp_operand_loader #(
  parameter int WORD_W = 32,
  parameter int N_BITS = 512
) (
  input  logic                 clk,
  input  logic                 resetn,
  exp_operand_loader_if.slave  s,
  input  logic                 cmd_start,
  output logic [N_BITS-1:0]    modulus,
  output logic [N_BITS-1:0]    rmodm,
  output logic [N_BITS-1:0]    rsquaredmodm,
  output logic [N_BITS-1:0]    exponent,
  output logic [N_BITS-1:0]    x,
  output logic                 exp_start,
  input  logic                 exp_done,
  input  logic [N_BITS-1:0]    exp_result,
  output logic                 busy,
  output logic                 err
);
  localparam int WORDS = N_BITS / WORD_W;
  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} state_t;
  state_t            state, state_d;
  logic [N_BITS-1:0] ops [5];
  logic [N_BITS-1:0] result;
  logic [CW-1:0]     cnt, idx;
  logic [2:0]        cur_sel;
  logic [4:0]        loaded;
  logic              in_fire, out_fire;
  assign in_fire = s.in_valid && s.in_ready && s.in_sel < 3'd5;
  assign out_fire = s.out_valid && s.out_ready;
  // switching operands mid-stream restarts the word count for the new operand
  assign idx = (s.in_sel == cur_sel) ? cnt : '0;
  assign s.in_ready = state == IDLE;
  assign s.out_valid = state == DRAIN;
  assign s.out_data = result[WORD_W-1:0];
  assign s.out_last = state == DRAIN && cnt == LAST;
  assign exp_start = state == START;
  assign busy = state != IDLE;
  assign modulus = ops[0];
  assign rmodm = ops[1];
  assign rsquaredmodm = ops[2];
  assign exponent = ops[3];
  assign x = ops[4];
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = (cmd_start && &loaded) ? START : IDLE;
      START:   state_d = WAIT;
      WAIT:    state_d = exp_done ? DRAIN : WAIT;
      DRAIN:   state_d = (out_fire && cnt == LAST) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      ops <= '{default: '0};
      result <= '0;
      cnt <= '0;
      cur_sel <= '0;
      loaded <= '0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      err <= state == IDLE && cmd_start && !(&loaded);
      if (in_fire) begin
        ops[s.in_sel] <= {s.in_data, ops[s.in_sel][N_BITS-1:WORD_W]};
        cur_sel <= s.in_sel;
        cnt <= (idx == LAST) ? '0 : idx + 1'b1;
        if (idx == '0) loaded[s.in_sel] <= 1'b0;
        if (idx == LAST) loaded[s.in_sel] <= 1'b1;
      end
      if (state == WAIT && exp_done) begin
        result <= exp_result;
        cnt <= '0;
      end
      if (out_fire) begin
        result <= result >> WORD_W;
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_exp_operand_loader.sv
// tb_exp_operand_loader: directed and randomized checks of operand loading, run control and result draining
module tb_exp_operand_loader;
  localparam int W = 32;
  localparam int N = 512;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic cmd_start = 1'b0;
  logic exp_done = 1'b0;
  logic [N-1:0] exp_result = '0;
  logic [N-1:0] o_mod, o_rm, o_r2, o_e, o_x;
  logic exp_start, busy, err;
  logic [N-1:0] model [5];
  int n_cmp = 0;
  int n_err = 0;
  exp_operand_loader_if #(.WORD_W(W)) bus ();
  exp_operand_loader #(.WORD_W(W), .N_BITS(N)) dut (
    .clk(clk), .resetn(resetn), .s(bus.slave), .cmd_start(cmd_start),
    .modulus(o_mod), .rmodm(o_rm), .rsquaredmodm(o_r2), .exponent(o_e), .x(o_x),
    .exp_start(exp_start), .exp_done(exp_done), .exp_result(exp_result),
    .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic chk_ops(input string tag);
    logic [N-1:0] a [5];
    a = '{o_mod, o_rm, o_r2, o_e, o_x};
    for (int i = 0; i < 5; i++) chk($sformatf("%s_op%0d", tag, i), a[i], model[i]);
  endtask
  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] r;
    for (int i = 0; i < N / W; i++) r[W*i +: W] = $urandom;
    return r;
  endfunction
  task automatic send(input logic [2:0] sel, input logic [W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_sel = sel;
    bus.in_data = d;
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic load_full(input logic [2:0] sel, input logic [N-1:0] v);
    for (int i = 0; i < N / W; i++) send(sel, v[W*i +: W]);
    model[sel] = v;
  endtask
  task automatic chk_reset(input string tag);
    for (int i = 0; i < 5; i++) model[i] = '0;
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_exp_start"}, exp_start, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_last"}, bus.out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk_ops(tag);
  endtask
  task automatic start_cmd();
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
  endtask
  task automatic expect_err(input string tag);
    start_cmd();
    chk({tag, "_err"}, err, 1);
    chk({tag, "_exp_start"}, exp_start, 0);
    chk({tag, "_busy"}, busy, 0);
    step();
    chk({tag, "_err_clr"}, err, 0);
    chk({tag, "_busy2"}, busy, 0);
    chk({tag, "_exp_start2"}, exp_start, 0);
  endtask
  task automatic launch(input string tag);
    start_cmd();
    chk({tag, "_exp_start"}, exp_start, 1);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_err"}, err, 0);
    step();
    chk({tag, "_exp_start_1cyc"}, exp_start, 0);
    chk({tag, "_in_ready_wait"}, bus.in_ready, 0);
  endtask
  task automatic finish_core(input string tag, input logic [N-1:0] res);
    chk({tag, "_no_valid_wait"}, bus.out_valid, 0);
    exp_done = 1'b1;
    exp_result = res;
    step();
    exp_done = 1'b0;
    exp_result = rand_op();
    chk({tag, "_drain_valid"}, bus.out_valid, 1);
  endtask
  task automatic drain(input string tag, input logic [N-1:0] res, input bit stall);
    int k = 0;
    int cyc = 0;
    while (k < N / W && cyc < 200) begin
      bus.out_ready = !stall || cyc % 4 == 0 || cyc % 4 == 3;
      chk($sformatf("%s_valid_w%0d", tag, k), bus.out_valid, 1);
      chk($sformatf("%s_data_w%0d", tag, k), bus.out_data, res[W*k +: W]);
      chk($sformatf("%s_last_w%0d", tag, k), bus.out_last, k == N / W - 1);
      step();
      if (bus.out_ready) k++;
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk({tag, "_handshakes"}, k, N / W);
    chk({tag, "_done_valid"}, bus.out_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
    chk({tag, "_done_in_ready"}, bus.in_ready, 1);
  endtask
  initial begin
    logic [N-1:0] rx, re, res;
    bus.in_valid = 1'b0;
    bus.in_sel = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk_reset("reset");
    resetn = 1'b1;
    load_full(0, 512'hB);
    load_full(1, 512'd4);
    load_full(2, 512'd5);
    load_full(3, 512'd3);
    expect_err("err_4ops");
    load_full(4, 512'd2);
    chk_ops("dir_load");
    launch("dir");
    bus.in_valid = 1'b1;
    bus.in_sel = 3'd4;
    bus.in_data = $urandom;
    cmd_start = 1'b1;
    step();
    chk("wait_in_ready", bus.in_ready, 0);
    chk("wait_cmd_err", err, 0);
    chk("wait_cmd_exp_start", exp_start, 0);
    chk("wait_busy", busy, 1);
    bus.in_valid = 1'b0;
    cmd_start = 1'b0;
    repeat (7) step();
    chk_ops("wait_hold");
    finish_core("dir", 512'd8);
    drain("dir_drain", 512'd8, 1'b0);
    exp_done = 1'b1;
    step();
    exp_done = 1'b0;
    chk("idle_done_valid", bus.out_valid, 0);
    chk("idle_done_busy", busy, 0);
    rx = rand_op();
    re = rand_op();
    for (int i = 0; i < 7; i++) send(3'd4, rx[W*i +: W]);
    load_full(3, re);
    model[4] = {rx[7*W-1:0], model[4][N-1:7*W]};
    send(3'd6, $urandom);
    chk_ops("switch");
    expect_err("err_x_partial");
    for (int r = 0; r < 3; r++) begin
      load_full(4, rand_op());
      res = rand_op();
      launch($sformatf("rnd%0d", r));
      repeat ($urandom_range(0, 20)) step();
      finish_core($sformatf("rnd%0d", r), res);
      drain($sformatf("rnd%0d_drain", r), res, r != 1);
      chk_ops($sformatf("rnd%0d_ops", r));
    end
    launch("rst_wait");
    step();
    resetn = 1'b0;
    step();
    chk_reset("rst_wait");
    resetn = 1'b1;
    expect_err("rst_wait_norel");
    for (int i = 0; i < 5; i++) load_full(3'(i), rand_op());
    chk_ops("reload");
    res = rand_op();
    launch("rst_drain");
    finish_core("rst_drain", res);
    bus.out_ready = 1'b1;
    repeat (5) step();
    chk("rst_drain_mid", bus.out_data, res[5*W +: W]);
    bus.out_ready = 1'b0;
    resetn = 1'b0;
    step();
    chk_reset("rst_drain");
    resetn = 1'b1;
    expect_err("rst_drain_norel");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
